// File: rtl/pong_game_engine.sv
// pong_game_engine: per-frame pong logic (paddles, ball, serve timing, scoring, win).
// Optional build macro AI_P2_EN: right paddle tracks the ball and ignores p2_up/p2_down.
`default_nettype none

module pong_game_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PAD_H        = 72,
  parameter int PAD_W        = 4,
  parameter int PAD1_X       = 32,
  parameter int PAD2_X       = 600,
  parameter int BALL_SZ      = 8,
  parameter int PAD_V        = 3,
  parameter int BALL_V       = 2,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               p1_up,
  input  logic               p1_down,
  input  logic               p2_up,
  input  logic               p2_down,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [9:0]         pad1_y,
  output logic [9:0]         pad2_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [2:0]         state,
  output logic               game_over
);

  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] PH      = 10'(PAD_H);
  localparam logic [9:0] BSZ     = 10'(BALL_SZ);
  localparam logic [9:0] PV      = 10'(PAD_V);
  localparam logic [9:0] BV      = 10'(BALL_V);
  localparam logic [9:0] P1_L    = 10'(PAD1_X);
  localparam logic [9:0] P1_R    = 10'(PAD1_X + PAD_W);
  localparam logic [9:0] P2_L    = 10'(PAD2_X);
  localparam logic [9:0] P2_R    = 10'(PAD2_X + PAD_W);
  localparam logic [9:0] P2_STOP = 10'(PAD2_X - BALL_SZ);
  localparam logic [9:0] BX0     = 10'((H_ACTIVE - BALL_SZ) / 2);
  localparam logic [9:0] BY0     = 10'((V_ACTIVE - BALL_SZ) / 2);
  localparam logic [9:0] BY_MAX  = 10'(V_ACTIVE - BALL_SZ);
  localparam logic [9:0] PY0     = 10'((V_ACTIVE - PAD_H) / 2);
  localparam logic [9:0] PY_MAX  = 10'(V_ACTIVE - PAD_H);

  localparam int                 CNT_W      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             state_q;
  logic [9:0]         ball_x_q, ball_y_q, pad1_q, pad2_q;
  logic [9:0]         ball_x_d, ball_y_d, pad1_d, pad2_d;
  logic [SCORE_W-1:0] score1_q, score2_q, score1_inc, score2_inc;
  logic [CNT_W-1:0]   serve_cnt_q;
  logic               dir_r_q, dir_dn_q, dir_r_d, dir_dn_d;
  logic               serve_dn_q, p2_scored_q, start_q, game_over_q;
  logic               start_edge, hit1, hit2, p1_point, p2_point;
  logic               p2_up_eff, p2_dn_eff;

  assign start_edge = start & ~start_q;
  assign score1_inc = score1_q + SCORE_ONE;
  assign score2_inc = score2_q + SCORE_ONE;

  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    logic [9:0] r;
    r = y;
    if (up && !dn) begin
      r = (y < PV) ? 10'd0 : y - PV;
    end else if (dn && !up) begin
      r = (y + PV > PY_MAX) ? PY_MAX : y + PV;
    end
    return r;
  endfunction

`ifdef AI_P2_EN
  localparam logic [9:0] PAD_HALF  = 10'(PAD_H / 2);
  localparam logic [9:0] BALL_HALF = 10'(BALL_SZ / 2);
  logic [9:0] pad2_ctr, ball_ctr;
  logic       unused_p2_keys;
  assign pad2_ctr       = pad2_q + PAD_HALF;
  assign ball_ctr       = ball_y_q + BALL_HALF;
  // Both comparisons add PAD_V to the smaller side so neither can underflow.
  assign p2_up_eff      = (ball_ctr + PV < pad2_ctr);
  assign p2_dn_eff      = (ball_ctr > pad2_ctr + PV);
  assign unused_p2_keys = p2_up ^ p2_down;
`else
  assign p2_up_eff = p2_up;
  assign p2_dn_eff = p2_down;
`endif

  assign pad1_d = pad_step(pad1_q, p1_up, p1_down);
  assign pad2_d = pad_step(pad2_q, p2_up_eff, p2_dn_eff);

  always_comb begin
    ball_y_d = ball_y_q;
    dir_dn_d = dir_dn_q;
    if (dir_dn_q) begin
      if (ball_y_q + BSZ + BV > V_ACT) begin
        ball_y_d = BY_MAX;
        dir_dn_d = 1'b0;
      end else begin
        ball_y_d = ball_y_q + BV;
      end
    end else begin
      if (ball_y_q < BV) begin
        ball_y_d = 10'd0;
        dir_dn_d = 1'b1;
      end else begin
        ball_y_d = ball_y_q - BV;
      end
    end

    hit1 = !dir_r_q && (ball_x_q <= P1_R) && (ball_x_q + BSZ > P1_L) &&
           (ball_y_q + BSZ > pad1_q) && (ball_y_q < pad1_q + PH);
    hit2 = dir_r_q && (ball_x_q + BSZ >= P2_L) && (ball_x_q < P2_R) &&
           (ball_y_q + BSZ > pad2_q) && (ball_y_q < pad2_q + PH);

    ball_x_d = ball_x_q;
    dir_r_d  = dir_r_q;
    p1_point = 1'b0;
    p2_point = 1'b0;
    if (hit1) begin
      ball_x_d = P1_R;
      dir_r_d  = 1'b1;
    end else if (hit2) begin
      ball_x_d = P2_STOP;
      dir_r_d  = 1'b0;
    end else if (!dir_r_q && (ball_x_q < BV)) begin
      p2_point = 1'b1;
    end else if (dir_r_q && (ball_x_q + BSZ + BV > H_ACT)) begin
      p1_point = 1'b1;
    end else if (dir_r_q) begin
      ball_x_d = ball_x_q + BV;
    end else begin
      ball_x_d = ball_x_q - BV;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ball_x_q    <= BX0;
      ball_y_q    <= BY0;
      pad1_q      <= PY0;
      pad2_q      <= PY0;
      score1_q    <= '0;
      score2_q    <= '0;
      serve_cnt_q <= '0;
      dir_r_q     <= 1'b1;
      dir_dn_q    <= 1'b1;
      serve_dn_q  <= 1'b1;
      p2_scored_q <= 1'b0;
      start_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q     <= S_SERVE;
            serve_cnt_q <= '0;
            ball_x_q    <= BX0;
            ball_y_q    <= BY0;
            dir_r_q     <= 1'b1;
            dir_dn_q    <= 1'b1;
            serve_dn_q  <= 1'b1;
          end
        end
        S_SERVE: begin
          if (tick) begin
            pad1_q      <= pad1_d;
            pad2_q      <= pad2_d;
            serve_cnt_q <= serve_cnt_q + CNT_W'(1);
            if (serve_cnt_q == SERVE_LAST) state_q <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (tick) begin
            pad1_q   <= pad1_d;
            pad2_q   <= pad2_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dir_r_q  <= dir_r_d;
            dir_dn_q <= dir_dn_d;
            if (p1_point || p2_point) begin
              state_q     <= S_POINT;
              p2_scored_q <= p2_point;
            end
          end
        end
        S_POINT: begin
          // Next serve heads toward whoever just conceded; vertical alternates.
          ball_x_q    <= BX0;
          ball_y_q    <= BY0;
          serve_cnt_q <= '0;
          dir_r_q     <= ~p2_scored_q;
          dir_dn_q    <= ~serve_dn_q;
          serve_dn_q  <= ~serve_dn_q;
          if (p2_scored_q) begin
            score2_q <= score2_inc;
            if (score2_inc == WIN) begin
              state_q     <= S_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= S_SERVE;
            end
          end else begin
            score1_q <= score1_inc;
            if (score1_inc == WIN) begin
              state_q     <= S_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= S_SERVE;
            end
          end
        end
        S_OVER: begin
          if (start_edge) begin
            state_q     <= S_IDLE;
            game_over_q <= 1'b0;
            score1_q    <= '0;
            score2_q    <= '0;
            pad1_q      <= PY0;
            pad2_q      <= PY0;
            ball_x_q    <= BX0;
            ball_y_q    <= BY0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign pad1_y    = pad1_q;
  assign pad2_y    = pad2_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign state     = state_q;
  assign game_over = game_over_q;

endmodule

`default_nettype wire
